serial_addsub_ctrl: RTL and testbench

SERIAL_ADDSUB_CTRL -- requirements
Module: serial_addsub_ctrl

---
 rtl/serial_addsub_pkg.sv | 15 +
 rtl/addsub_bit_cell.sv | 23 ++
 rtl/serial_addsub_ctrl.sv | 111 +++++++++++
 tb/tb_serial_addsub_ctrl.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/serial_addsub_pkg.sv
// Shared constants for the bit-serial add/subtract block.
package serial_addsub_pkg;

  localparam int unsigned WIDTH_DEFAULT = 8;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/addsub_bit_cell.sv
// One-bit full adder / full subtractor cell selected by op.
module addsub_bit_cell
  import serial_addsub_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic cb_in,
  input  logic op,
  output logic d,
  output logic cb_out
);

  // Sum/difference bit is identical for both operations; only the carry/borrow differs.
  always_comb begin
    d = a ^ b ^ cb_in;
    if (op == OP_SUB) begin
      cb_out = (~a & b) | (~(a ^ b) & cb_in);
    end else begin
      cb_out = (a & b) | ((a ^ b) & cb_in);
    end
  end

endmodule

// File: rtl/serial_addsub_ctrl.sv
// Bit-serial add/subtract controller: one bit per cycle, LSB first.
module serial_addsub_ctrl
  import serial_addsub_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic               cb_q;
  logic               op_q;
  logic [WIDTH-1:0]   a_sh_q, b_sh_q;
  logic [WIDTH-2:0]   acc_q;
  logic [WIDTH-1:0]   result_q;
  logic               cout_q, busy_q, done_q;

  logic               cell_d, cell_cb;
  logic               last_c;
  logic [WIDTH-1:0]   acc_full_c;

  addsub_bit_cell u_cell (
    .a      (a_sh_q[0]),
    .b      (b_sh_q[0]),
    .cb_in  (cb_q),
    .op     (op_q),
    .d      (cell_d),
    .cb_out (cell_cb)
  );

  // Final bit of the operation and the completed value including the bit in flight.
  always_comb begin
    last_c     = (cnt_q == CNT_W'(WIDTH - 1));
    acc_full_c = {cell_d, acc_q};
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last_c) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register, registered status flags and serial datapath.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
      cnt_q    <= '0;
      cb_q     <= 1'b0;
      op_q     <= OP_ADD;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      acc_q    <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d == RUN);
      done_q  <= (state_d == DONE);
      case (state_q)
        IDLE: begin
          if (start) begin
            a_sh_q <= a;
            b_sh_q <= b;
            // Anything other than a clean subtract code (including X/Z) runs as add.
            if (op == OP_SUB) op_q <= OP_SUB;
            else              op_q <= OP_ADD;
            cb_q  <= 1'b0;
            cnt_q <= '0;
          end
        end
        RUN: begin
          a_sh_q <= a_sh_q >> 1;
          b_sh_q <= b_sh_q >> 1;
          acc_q  <= acc_full_c[WIDTH-1:1];
          cb_q   <= cell_cb;
          cnt_q  <= cnt_q + CNT_W'(1);
          if (last_c) begin
            result_q <= acc_full_c;
            cout_q   <= cell_cb;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign cout   = cout_q;

endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// Self-checking bench: transaction-level model plus directed literal cases and random traffic.
module tb_serial_addsub_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         op = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, cout;
  logic [W-1:0] result;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  serial_addsub_ctrl #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .cout   (cout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Model: an accepted request yields an arithmetic answer that appears W edges later.
  int           t = -1;
  logic         m_busy = 1'b0, m_done = 1'b0, m_cout = 1'b0, p_c = 1'b0;
  logic [W-1:0] m_result = '0, p_r = '0;

  always @(posedge clk) begin
    if (rst) begin
      t = -1; m_busy = 1'b0; m_done = 1'b0; m_result = '0; m_cout = 1'b0;
    end else begin
      m_done = 1'b0;
      if (t < 0) begin
        if (start) begin
          t = 0;
          if (op) begin
            p_r = a - b;
            p_c = (a < b);
          end else begin
            {p_c, p_r} = {1'b0, a} + {1'b0, b};
          end
        end
      end else if (t == W) begin
        t = -1;
      end else begin
        t++;
        if (t == W) begin
          m_result = p_r; m_cout = p_c; m_done = 1'b1;
        end
      end
      m_busy = (t >= 0 && t < W);
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_busy", 32'(busy), 32'(m_busy));
      chk("cyc_done", 32'(done), 32'(m_done));
      chk("cyc_result", 32'(result), 32'(m_result));
      chk("cyc_cout", 32'(cout), 32'(m_cout));
    end
  end

  task automatic do_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic iop,
                       input logic [W-1:0] er, input logic ec, input string nm);
    int n;
    bit got;
    @(negedge clk);
    a = ia; b = ib; op = iop; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = W'($urandom); b = W'($urandom); op = 1'($urandom);
    n = 0; got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (done) got = 1'b1;
      else begin
        if (busy) n++;
        @(negedge clk);
      end
    end
    chk({nm, "_done_seen"}, 32'(got), 32'd1);
    chk({nm, "_busy_cycles"}, 32'(n), 32'(W));
    chk({nm, "_result"}, 32'(result), 32'(er));
    chk({nm, "_cout"}, 32'(cout), 32'(ec));
    chk({nm, "_model_result"}, 32'(m_result), 32'(er));
    @(negedge clk);
  endtask

  initial begin
    int ndone;
    logic [W-1:0] rs[$];

    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_result", 32'(result), 32'd0);
    chk("reset_cout", 32'(cout), 32'd0);
    chk_en = 1'b1;
    rst = 1'b0;

    do_op(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, "add");
    do_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, "add_ovf");
    do_op(8'h10, 8'h01, 1'b1, 8'h0F, 1'b0, "sub");
    do_op(8'h00, 8'h01, 1'b1, 8'hFF, 1'b1, "sub_borrow");

    // Start with new operands during RUN is ignored.
    @(negedge clk);
    a = 8'h5A; b = 8'h3C; op = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ndone = 0;
    for (int i = 0; i < 20; i++) begin
      if (i == 2) begin a = 8'h11; b = 8'h22; op = 1'b1; start = 1'b1; end
      if (i == 3) start = 1'b0;
      if (done) begin
        ndone++;
        chk("ignore_start_result", 32'(result), 32'h96);
      end
      @(negedge clk);
    end
    chk("ignore_start_ndone", 32'(ndone), 32'd1);

    // Reset mid-run aborts the operation.
    @(negedge clk);
    a = 8'h77; b = 8'h11; op = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_result", 32'(result), 32'd0);
    chk("abort_cout", 32'(cout), 32'd0);
    ndone = 0;
    for (int i = 0; i < 15; i++) begin
      if (done) ndone++;
      @(negedge clk);
    end
    chk("abort_ndone", 32'(ndone), 32'd0);
    do_op(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, "after_abort");

    // Back-to-back with start held high.
    a = 8'd3; b = 8'd4; op = 1'b0; start = 1'b1;
    @(negedge clk);
    a = 8'd9; b = 8'd2; op = 1'b1;
    for (int k = 1; k < 30; k++) begin
      if (k == 11) start = 1'b0;
      if (done) rs.push_back(result);
      @(negedge clk);
    end
    chk("b2b_ndone", 32'(rs.size()), 32'd2);
    if (rs.size() == 2) begin
      chk("b2b_first", 32'(rs[0]), 32'h07);
      chk("b2b_second", 32'(rs[1]), 32'h07);
    end

    // Random traffic, including input churn mid-run and occasional resets.
    for (int i = 0; i < 600; i++) begin
      a = W'($urandom);
      b = W'($urandom);
      op = 1'($urandom);
      start = ($urandom_range(0, 2) == 0);
      rst = ($urandom_range(0, 59) == 0);
      @(negedge clk);
    end
    rst = 1'b0; start = 1'b0;
    repeat (12) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
